// File: rtl/uart_tx_sched_if.sv
// Request handshake and register-port bus shared by the UART TX scheduler.
// Signal names are written from the scheduler's point of view: i_* flows into
// the scheduler, o_* flows out of it.
interface uart_tx_sched_if #(
    parameter int G_NUM_REQ    = 4,
    parameter int G_WORD_WIDTH = 8
);
    // Requester side: one valid/ready pair and one byte lane per requester.
    logic [G_NUM_REQ-1:0]              i_req_valid;
    logic [G_NUM_REQ*G_WORD_WIDTH-1:0] i_req_data;
    logic [G_NUM_REQ-1:0]              o_req_ready;

    // UART register port: address 0 is TX data, address 1 is RX data.
    logic                    o_wb_stb;
    logic                    o_wb_we;
    logic                    o_wb_addr;
    logic [G_WORD_WIDTH-1:0] o_wb_data;
    logic                    i_wb_ack;
    logic [G_WORD_WIDTH-1:0] i_wb_data;

    // The scheduler drives the register port and answers the requesters.
    modport master (
        input  i_req_valid,
        input  i_req_data,
        output o_req_ready,
        output o_wb_stb,
        output o_wb_we,
        output o_wb_addr,
        output o_wb_data,
        input  i_wb_ack,
        input  i_wb_data
    );

    // The environment: requesters plus the UART register block.
    modport slave (
        output i_req_valid,
        output i_req_data,
        input  o_req_ready,
        input  o_wb_stb,
        input  o_wb_we,
        input  o_wb_addr,
        input  o_wb_data,
        output i_wb_ack,
        output i_wb_data
    );
endinterface

// File: rtl/uart_tx_sched.sv
// UART access scheduler: arbitrates several byte requesters round-robin onto
// the UART TX data register, paces writes on the transmitter busy flag, and
// drains received bytes from the RX data register with priority over TX.
module uart_tx_sched #(
    parameter int G_NUM_REQ    = 4,
    parameter int G_WORD_WIDTH = 8,
    parameter int G_TIMEOUT    = 4096
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    uart_tx_sched_if.master              bus,
    input  logic                         i_tx_busy,
    input  logic                         i_rx_busy,
    output logic                         o_rx_valid,
    output logic [G_WORD_WIDTH-1:0]      o_rx_data,
    output logic [$clog2(G_NUM_REQ)-1:0] o_grant_id,
    output logic                         o_busy,
    output logic                         o_timeout,
    output logic                         o_rx_overrun
);

    localparam int GW = $clog2(G_NUM_REQ);
    localparam int CW = $clog2(G_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_t;

    state_t                  state_q, state_d;
    logic                    rx_busy_q;
    logic                    rx_pending_q, rx_pending_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic [GW-1:0]           grant_id_q, grant_id_d;
    logic [G_WORD_WIDTH-1:0] tx_reg_q, tx_reg_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [G_WORD_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    timeout_q, timeout_d;
    logic                    overrun_q, overrun_d;

    logic                    grant_found;
    logic [GW-1:0]           grant_idx;
    logic [G_WORD_WIDTH-1:0] grant_byte;
    logic                    grant_fire;
    logic                    wr_ack;
    logic                    rd_ack;
    logic                    rx_done;
    logic                    timeout_hit;

    // Round-robin search starting just after the previous winner.
    function automatic logic [GW:0] rr_pick(input logic [G_NUM_REQ-1:0] valid,
                                            input logic [GW-1:0]        last);
        logic          found;
        logic [GW-1:0] idx;
        logic [GW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= G_NUM_REQ; i++) begin
            cand = GW'((int'(last) + i) % G_NUM_REQ);
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign {grant_found, grant_idx} = rr_pick(bus.i_req_valid, last_grant_q);

    // A pending RX read blocks any TX grant while idle.
    assign grant_fire  = (state_q == ST_IDLE) && !rx_pending_q && grant_found;
    assign wr_ack      = (state_q == ST_WR) && bus.i_wb_ack;
    assign rd_ack      = (state_q == ST_RD) && bus.i_wb_ack;
    assign rx_done     = rx_busy_q && !i_rx_busy;
    assign timeout_hit = (state_q == ST_WAIT_HI) && !i_tx_busy &&
                         (cnt_q == CW'(G_TIMEOUT - 1));

    // Select the winning requester's byte lane.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_byte = '0;
        for (int k = 0; k < G_NUM_REQ; k++) begin
            if (grant_idx == GW'(k)) begin
                grant_byte = bus.i_req_data[k*G_WORD_WIDTH +: G_WORD_WIDTH];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: clocked state uses non-blocking assignment so all registers update together at the edge.
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_pending_q) begin
                    state_d = ST_RD;
                end else if (grant_found) begin
                    state_d = ST_WR;
                end
            end
            ST_RD: begin
                if (bus.i_wb_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (bus.i_wb_ack) begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (i_tx_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!i_tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: register-port strobes and the requester accept pulse.
    always_comb begin
        bus.o_wb_stb    = 1'b0;
        bus.o_wb_we     = 1'b0;
        bus.o_wb_addr   = 1'b0;
        bus.o_wb_data   = '0;
        bus.o_req_ready = '0;
        o_busy          = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                // Gated by reset so no byte appears accepted while reset is held.
                if (grant_fire && !i_rst) begin
                    bus.o_req_ready = G_NUM_REQ'(1) << grant_idx;
                end
            end
            ST_WR: begin
                bus.o_wb_stb  = 1'b1;
                bus.o_wb_we   = 1'b1;
                bus.o_wb_data = tx_reg_q;
            end
            ST_RD: begin
                bus.o_wb_stb  = 1'b1;
                bus.o_wb_addr = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next-state: grant capture, RX bookkeeping, timeout counter.
    always_comb begin
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_reg_d     = tx_reg_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rd_ack;
        timeout_d    = timeout_hit;
        overrun_d    = rx_done && rx_pending_q && !rd_ack;
        cnt_d        = cnt_q;

        if (grant_fire) begin
            last_grant_d = grant_idx;
            grant_id_d   = grant_idx;
            tx_reg_d     = grant_byte;
        end

        // A new RX-done wins over a same-cycle clear so that byte is not lost.
        if (rx_done) begin
            rx_pending_d = 1'b1;
        end else if (rd_ack) begin
            rx_pending_d = 1'b0;
        end else begin
            rx_pending_d = rx_pending_q;
        end

        if (rd_ack) begin
            rx_data_d = bus.i_wb_data;
        end

        // Counter restarts on the TX write ack, i.e. on entry to WAIT_HI.
        if (wr_ack) begin
            cnt_d = '0;
        end else if (state_q == ST_WAIT_HI) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_busy_q    <= 1'b0;
            rx_pending_q <= 1'b0;
            last_grant_q <= GW'(G_NUM_REQ - 1);
            grant_id_q   <= '0;
            tx_reg_q     <= '0;
            cnt_q        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_busy_q    <= i_rx_busy;
            rx_pending_q <= rx_pending_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_reg_q     <= tx_reg_d;
            cnt_q        <= cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_rx_valid   = rx_valid_q;
    assign o_rx_data    = rx_data_q;
    assign o_grant_id   = grant_id_q;
    assign o_timeout    = timeout_q;
    assign o_rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a responder models the UART register block
// and TX busy flag, a monitor logs grants/writes/reads, and the main sequence
// compares the logs against hand-computed expectations.
module tb_uart_tx_sched;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst;
    logic i_tx_busy, i_rx_busy;
    logic o_rx_valid, o_busy, o_timeout, o_rx_overrun;
    logic [W-1:0] o_rx_data;
    logic [$clog2(N)-1:0] o_grant_id;

    always #5 clk = ~clk;

    uart_tx_sched_if #(.G_NUM_REQ(N), .G_WORD_WIDTH(W)) bus ();

    uart_tx_sched #(.G_NUM_REQ(N), .G_WORD_WIDTH(W), .G_TIMEOUT(T)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus),
        .i_tx_busy    (i_tx_busy),
        .i_rx_busy    (i_rx_busy),
        .o_rx_valid   (o_rx_valid),
        .o_rx_data    (o_rx_data),
        .o_grant_id   (o_grant_id),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout),
        .o_rx_overrun (o_rx_overrun)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Responder controls, set by the main sequence.
    bit         wr_ack_en    = 1'b1;
    bit         rd_ack_en    = 1'b1;
    bit         tx_resp_en   = 1'b1;
    int         busy_len_cfg = 0;
    logic [W-1:0] rd_data    = 8'h3C;
    int         busy_tbl [5] = '{2, 5, 10, 3, 7};

    // Monitor logs: grant index, event order (grant k or 8 for an RX read), writes.
    int grant_q [$];
    int ev_q    [$];
    int wr_q    [$];
    int cyc = 0;
    int n_rx_valid = 0, n_overrun = 0, n_timeout = 0, n_bad_ready = 0;
    int t_wr_ack = 0, t_timeout = 0;
    logic busy_at_to = 1'b1;
    logic [W-1:0] last_rx = '0;

    logic [W-1:0] req_bytes [N] = '{8'h11, 8'h22, 8'hA5, 8'h44};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_logs();
        grant_q.delete();
        ev_q.delete();
        wr_q.delete();
        n_rx_valid = 0;
        n_overrun  = 0;
        n_timeout  = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            #2;
            n++;
        end while ((o_busy !== 1'b0) && n < 300);
        check(tag, {31'b0, o_busy}, 32'd0);
    endtask

    function automatic logic [31:0] outs_vec();
        return {5'b0, bus.o_wb_stb, bus.o_wb_we, bus.o_wb_addr, bus.o_wb_data, bus.o_req_ready,
                o_rx_valid, o_rx_data, o_timeout, o_rx_overrun, o_busy};
    endfunction

    // Responder: acks a strobe on its second cycle, then raises tx_busy after a write.
    initial begin
        int  stb_age, busy_left, tx_n;
        bit  busy_arm;
        stb_age = 0; busy_left = 0; tx_n = 0; busy_arm = 1'b0;
        bus.i_wb_ack  = 1'b0;
        bus.i_wb_data = '0;
        i_tx_busy     = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_wb_ack  = 1'b0;
            bus.i_wb_data = rd_data;
            if (rst === 1'b1) begin
                stb_age = 0; busy_left = 0; busy_arm = 1'b0;
                i_tx_busy = 1'b0;
            end else begin
                if (busy_arm) begin
                    busy_left = (busy_len_cfg > 0) ? busy_len_cfg : busy_tbl[tx_n % 5];
                    tx_n++;
                    busy_arm = 1'b0;
                end
                if (busy_left > 0) begin
                    i_tx_busy = 1'b1;
                    busy_left--;
                end else begin
                    i_tx_busy = 1'b0;
                end
                if (bus.o_wb_stb === 1'b1 && (bus.o_wb_we ? wr_ack_en : rd_ack_en)) begin
                    if (stb_age >= 1) begin
                        bus.i_wb_ack = 1'b1;
                        stb_age = 0;
                        if (bus.o_wb_we && tx_resp_en) busy_arm = 1'b1;
                    end else begin
                        stb_age++;
                    end
                end else begin
                    stb_age = 0;
                end
            end
        end
    end

    // Monitor: samples 1 ns after the drivers, well away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst === 1'b0) begin
                if (|bus.o_req_ready) begin
                    int idx;
                    idx = 0;
                    for (int k = 0; k < N; k++) if (bus.o_req_ready[k]) idx = k;
                    grant_q.push_back(idx);
                    ev_q.push_back(idx);
                    if ($countones(bus.o_req_ready) != 1 || (bus.o_req_ready & ~bus.i_req_valid) != '0)
                        n_bad_ready++;
                end
                if (bus.o_wb_stb && bus.o_wb_we && bus.i_wb_ack) begin
                    wr_q.push_back(int'({bus.o_wb_addr, bus.o_wb_data}));
                    t_wr_ack = cyc;
                end
                if (bus.o_wb_stb && !bus.o_wb_we && bus.i_wb_ack) ev_q.push_back(8);
                if (o_rx_valid) begin
                    n_rx_valid++;
                    last_rx = o_rx_data;
                end
                if (o_rx_overrun) n_overrun++;
                if (o_timeout) begin
                    n_timeout++;
                    t_timeout  = cyc;
                    busy_at_to = o_busy;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Main directed sequence.
    initial begin
        int n;
        int exp_g [5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        i_rx_busy = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_data  = {req_bytes[3], req_bytes[2], req_bytes[1], req_bytes[0]};
        repeat (2) tick();
        bus.i_req_valid = 4'hF;
        tick(); #2;
        check("rst_outs", outs_vec(), 32'd0);
        check("rst_grant_id", 32'(o_grant_id), 32'd0);

        // All four requesters continuously valid: grants 0,1,2,3,0.
        tick();
        clear_logs();
        rst = 1'b0;
        n = 0;
        while (wr_q.size() < 5 && n < 400) begin tick(); #2; n++; end
        check("t1_writes", wr_q.size(), 32'd5);
        tick();
        bus.i_req_valid = '0;
        wait_idle("t1_idle");
        check("t1_grants", grant_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("t1_grant", (i < grant_q.size()) ? grant_q[i] : -1, exp_g[i]);
            check("t1_data", (i < wr_q.size()) ? wr_q[i] : -1, {24'b0, req_bytes[exp_g[i]]});
        end

        // Only requester 2 valid with 0xA5.
        tick();
        clear_logs();
        bus.i_req_valid = 4'b0100;
        n = 0;
        while (grant_q.size() < 1 && n < 50) begin tick(); #2; n++; end
        tick();
        bus.i_req_valid = '0;
        wait_idle("t2_idle");
        check("t2_grants", grant_q.size(), 32'd1);
        check("t2_grant", (grant_q.size() > 0) ? grant_q[0] : -1, 32'd2);
        check("t2_writes", wr_q.size(), 32'd1);
        check("t2_wr_addr_data", (wr_q.size() > 0) ? wr_q[0] : -1, 32'h0A5);
        check("t2_grant_id", 32'(o_grant_id), 32'd2);

        // RX-done during WAIT_LO while requester 1 waits: RD goes first.
        tick();
        clear_logs();
        rd_data = 8'h3C;
        busy_len_cfg = 8;
        bus.i_req_valid = 4'b0010;
        n = 0;
        while (i_tx_busy !== 1'b1 && n < 50) begin tick(); #2; n++; end
        check("t3_txbusy_seen", {31'b0, i_tx_busy}, 32'd1);
        tick(); i_rx_busy = 1'b1;
        tick();
        tick(); i_rx_busy = 1'b0;
        n = 0;
        while (ev_q.size() < 3 && n < 100) begin tick(); #2; n++; end
        tick();
        bus.i_req_valid = '0;
        wait_idle("t3_idle");
        check("t3_ev0", (ev_q.size() > 0) ? ev_q[0] : -1, 32'd1);
        check("t3_ev1_rd", (ev_q.size() > 1) ? ev_q[1] : -1, 32'd8);
        check("t3_ev2", (ev_q.size() > 2) ? ev_q[2] : -1, 32'd1);
        check("t3_rx_valid_cnt", n_rx_valid, 32'd1);
        check("t3_rx_data", {24'b0, last_rx}, 32'h3C);
        check("t3_overrun_cnt", n_overrun, 32'd0);

        // Two RX-done events before the read completes: one overrun, one rx_valid.
        tick();
        clear_logs();
        busy_len_cfg = 0;
        rd_ack_en = 1'b0;
        rd_data = 8'h5A;
        i_rx_busy = 1'b1;
        tick(); i_rx_busy = 1'b0;
        repeat (4) tick();
        i_rx_busy = 1'b1;
        tick(); i_rx_busy = 1'b0;
        repeat (3) tick();
        #2;
        check("t4_rd_held", {29'b0, bus.o_wb_stb, bus.o_wb_we, bus.o_wb_addr}, 32'b101);
        tick();
        rd_ack_en = 1'b1;
        n = 0;
        while (n_rx_valid < 1 && n < 50) begin tick(); #2; n++; end
        repeat (10) tick();
        wait_idle("t4_idle");
        check("t4_overrun_cnt", n_overrun, 32'd1);
        check("t4_rx_valid_cnt", n_rx_valid, 32'd1);
        check("t4_rx_data", {24'b0, last_rx}, 32'h5A);

        // tx_busy never rises: timeout 16 cycles after WAIT_HI entry.
        tick();
        clear_logs();
        tx_resp_en = 1'b0;
        bus.i_req_valid = 4'b0001;
        n = 0;
        while (grant_q.size() < 1 && n < 50) begin tick(); #2; n++; end
        tick();
        bus.i_req_valid = '0;
        n = 0;
        while (n_timeout < 1 && n < 80) begin tick(); #2; n++; end
        check("t5_timeout_seen", n_timeout, 32'd1);
        check("t5_latency", t_timeout - t_wr_ack, 32'd17);
        check("t5_busy_at_timeout", {31'b0, busy_at_to}, 32'd0);
        tick();
        tx_resp_en = 1'b1;
        busy_len_cfg = 3;
        bus.i_req_valid = 4'b1000;
        n = 0;
        while (grant_q.size() < 2 && n < 50) begin tick(); #2; n++; end
        tick();
        bus.i_req_valid = '0;
        wait_idle("t5_idle");
        check("t5_grant0", (grant_q.size() > 0) ? grant_q[0] : -1, 32'd0);
        check("t5_grant1", (grant_q.size() > 1) ? grant_q[1] : -1, 32'd3);
        check("t5_timeout_cnt", n_timeout, 32'd1);

        // Reset while stb is held in WR, with an RX byte pending.
        tick();
        clear_logs();
        wr_ack_en = 1'b0;
        bus.i_req_valid = 4'b0100;
        n = 0;
        while (bus.o_wb_stb !== 1'b1 && n < 50) begin tick(); #2; n++; end
        check("t6_stb_seen", {31'b0, bus.o_wb_stb}, 32'd1);
        tick(); i_rx_busy = 1'b1;
        tick(); i_rx_busy = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick(); #2;
        check("t6_stb_drop", {31'b0, bus.o_wb_stb}, 32'd0);
        check("t6_outs", outs_vec(), 32'd0);
        check("t6_grant_id", 32'(o_grant_id), 32'd0);
        tick();
        clear_logs();
        wr_ack_en = 1'b1;
        bus.i_req_valid = 4'hF;
        rst = 1'b0;
        n = 0;
        while (grant_q.size() < 1 && n < 50) begin tick(); #2; n++; end
        tick();
        bus.i_req_valid = '0;
        wait_idle("t6_idle");
        repeat (5) tick();
        check("t6_first_ev", (ev_q.size() > 0) ? ev_q[0] : -1, 32'd0);
        check("t6_grants", grant_q.size(), 32'd1);
        check("t6_rx_valid_cnt", n_rx_valid, 32'd0);
        check("t6_overrun_cnt", n_overrun, 32'd0);

        check("ready_protocol", n_bad_ready, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
